// File: rtl/histeq_frame_ctrl.sv
// Frame-level sequencer for histogram equalization: gates statistics to whole frames,
// then drains per-level counts and clears the histogram RAM during vertical blanking.
module histeq_frame_ctrl #(
    parameter int unsigned LEVELS    = 256,
    parameter int unsigned LVL_W     = 8,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned PIX_CNT_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 img_vsync,
    input  logic                 img_href,
    output logic                 stat_en,
    output logic                 lvl_rd_en,
    output logic [LVL_W-1:0]     lvl_rd_addr,
    output logic                 lvl_rd_last,
    output logic                 clr_en,
    output logic [LVL_W-1:0]     clr_addr,
    output logic                 histEQ_start_flag,
    output logic                 busy,
    output logic                 frame_drop,
    output logic [PIX_CNT_W-1:0] frame_pix_cnt
);

    typedef enum logic [2:0] {
        StIdle, StInitClr, StWaitSof, StStat, StXfer, StDrain, StClear
    } state_e;

    localparam logic [LVL_W-1:0] LastLvl   = LVL_W'(LEVELS - 1);
    localparam logic [LVL_W-1:0] DrainLast = LVL_W'(RD_LAT - 1);

    state_e               state_q, state_d;
    logic [LVL_W-1:0]     cnt_q, cnt_d;
    logic [PIX_CNT_W-1:0] pix_q, pix_d;
    logic [PIX_CNT_W-1:0] fpc_q, fpc_d;
    logic                 flag_q, flag_d;
    logic                 vsync_d_q;
    logic                 drop_d;
    logic                 sof, eof;

    logic                 stat_en_q, lvl_rd_en_q, lvl_rd_last_q, clr_en_q, busy_q, drop_q;
    logic [LVL_W-1:0]     lvl_rd_addr_q, clr_addr_q;

    assign sof = img_vsync & ~vsync_d_q;
    assign eof = ~img_vsync & vsync_d_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pix_d   = pix_q;
        fpc_d   = fpc_q;
        flag_d  = flag_q;
        // A frame start outside WAIT_SOF/STAT cannot be collected.
        drop_d  = sof && (state_q inside {StInitClr, StXfer, StDrain, StClear});
        unique case (state_q)
            StIdle: begin
                flag_d = 1'b0;
                if (enable) begin
                    state_d = StInitClr;
                    cnt_d   = '0;
                end
            end
            StInitClr: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastLvl) begin
                    state_d = StWaitSof;
                    cnt_d   = '0;
                end
            end
            StWaitSof: begin
                if (!enable) begin
                    state_d = StIdle;
                    flag_d  = 1'b0;
                end else if (sof) begin
                    state_d = StStat;
                    pix_d   = '0;
                end
            end
            StStat: begin
                if (img_href && (pix_q != '1)) begin
                    pix_d = pix_q + 1'b1;
                end
                if (eof) begin
                    state_d = StXfer;
                    fpc_d   = pix_q;
                    cnt_d   = '0;
                end
            end
            StXfer: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastLvl) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end
            end
            StDrain: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DrainLast) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastLvl) begin
                    cnt_d   = '0;
                    state_d = enable ? StWaitSof : StIdle;
                    flag_d  = enable;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            pix_q         <= '0;
            fpc_q         <= '0;
            flag_q        <= 1'b0;
            vsync_d_q     <= 1'b0;
            stat_en_q     <= 1'b0;
            lvl_rd_en_q   <= 1'b0;
            lvl_rd_addr_q <= '0;
            lvl_rd_last_q <= 1'b0;
            clr_en_q      <= 1'b0;
            clr_addr_q    <= '0;
            busy_q        <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pix_q         <= pix_d;
            fpc_q         <= fpc_d;
            flag_q        <= flag_d;
            vsync_d_q     <= img_vsync;
            stat_en_q     <= (state_d == StStat);
            lvl_rd_en_q   <= (state_d == StXfer);
            lvl_rd_addr_q <= (state_d == StXfer) ? cnt_d : '0;
            lvl_rd_last_q <= (state_d == StXfer) && (cnt_d == LastLvl);
            clr_en_q      <= (state_d inside {StInitClr, StClear});
            clr_addr_q    <= (state_d inside {StInitClr, StClear}) ? cnt_d : '0;
            busy_q        <= (state_d != StIdle);
            drop_q        <= drop_d;
        end
    end

    assign stat_en           = stat_en_q;
    assign lvl_rd_en         = lvl_rd_en_q;
    assign lvl_rd_addr       = lvl_rd_addr_q;
    assign lvl_rd_last       = lvl_rd_last_q;
    assign clr_en            = clr_en_q;
    assign clr_addr          = clr_addr_q;
    assign histEQ_start_flag = flag_q;
    assign busy              = busy_q;
    assign frame_drop        = drop_q;
    assign frame_pix_cnt     = fpc_q;

endmodule

// File: tb/tb_histeq_frame_ctrl.sv
// Directed self-checking bench for histeq_frame_ctrl; pixel counter narrowed to 10 bits
// so saturation is reachable in a short run.
module tb_histeq_frame_ctrl;

    localparam int PW = 10;

    logic          clk = 1'b0;
    logic          rst, enable, img_vsync, img_href;
    logic          stat_en, lvl_rd_en, lvl_rd_last, clr_en, histEQ_start_flag, busy, frame_drop;
    logic [7:0]    lvl_rd_addr, clr_addr;
    logic [PW-1:0] frame_pix_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    histeq_frame_ctrl #(
        .LEVELS(256), .LVL_W(8), .RD_LAT(2), .PIX_CNT_W(PW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .img_vsync(img_vsync), .img_href(img_href),
        .stat_en(stat_en), .lvl_rd_en(lvl_rd_en), .lvl_rd_addr(lvl_rd_addr),
        .lvl_rd_last(lvl_rd_last), .clr_en(clr_en), .clr_addr(clr_addr),
        .histEQ_start_flag(histEQ_start_flag), .busy(busy), .frame_drop(frame_drop),
        .frame_pix_cnt(frame_pix_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for a clear sweep to start and finish, bounded.
    task automatic wait_clr_done(input string tag);
        int n = 0;
        while (clr_en !== 1'b1 && n < 2000) begin tick(); n++; end
        while (clr_en === 1'b1 && n < 2000) begin tick(); n++; end
        n_checks++;
        if (n >= 2000) begin
            n_fail++;
            $display("FAIL %s: clear sweep timeout, cycles=%0d required < 2000", tag, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; img_vsync = 1'b0; img_href = 1'b0;
        tick(); tick();
        n_checks++;
        if ({stat_en, lvl_rd_en, lvl_rd_addr, lvl_rd_last, clr_en, clr_addr,
             histEQ_start_flag, busy, frame_drop, frame_pix_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got st=%b rd=%b ra=%0d cl=%b ca=%0d fl=%b bz=%b dr=%b pc=%0d required all 0",
                     stat_en, lvl_rd_en, lvl_rd_addr, clr_en, clr_addr, histEQ_start_flag,
                     busy, frame_drop, frame_pix_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_init_clear();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 256; i++) begin
            n_checks++;
            if (clr_en !== 1'b1 || clr_addr !== 8'(i) || busy !== 1'b1 ||
                histEQ_start_flag !== 1'b0 || lvl_rd_en !== 1'b0 || stat_en !== 1'b0) begin
                n_fail++;
                $display("FAIL init_clr[%0d]: clr_en=%b addr=%0d busy=%b flag=%b required 1 %0d 1 0",
                         i, clr_en, clr_addr, busy, histEQ_start_flag, i);
            end
            tick();
        end
        n_checks++;
        if (clr_en !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL init_clr_end: clr_en=%b busy=%b required 0 1", clr_en, busy);
        end
    endtask

    task automatic test_frame();
        img_vsync = 1'b1; img_href = 1'b0;
        n_checks++;
        if (stat_en !== 1'b0) begin
            n_fail++; $display("FAIL stat_pre_sof: stat_en=%b required 0", stat_en);
        end
        tick();
        n_checks++;
        if (stat_en !== 1'b1) begin
            n_fail++; $display("FAIL stat_rise: stat_en=%b required 1", stat_en);
        end
        for (int l = 0; l < 4; l++) begin
            img_href = 1'b1; repeat (10) tick();
            img_href = 1'b0; repeat (3) tick();
        end
        n_checks++;
        if (stat_en !== 1'b1) begin
            n_fail++; $display("FAIL stat_hold: stat_en=%b required 1", stat_en);
        end
        img_vsync = 1'b0;
        tick();
        n_checks++;
        if (stat_en !== 1'b0 || frame_pix_cnt !== PW'(40)) begin
            n_fail++;
            $display("FAIL frame_end: stat_en=%b pix=%0d required 0 40", stat_en, frame_pix_cnt);
        end
        for (int i = 0; i < 256; i++) begin
            n_checks++;
            if (lvl_rd_en !== 1'b1 || lvl_rd_addr !== 8'(i) || lvl_rd_last !== (i == 255) ||
                clr_en !== 1'b0 || stat_en !== 1'b0) begin
                n_fail++;
                $display("FAIL xfer[%0d]: rd_en=%b addr=%0d last=%b clr=%b required 1 %0d %b 0",
                         i, lvl_rd_en, lvl_rd_addr, lvl_rd_last, clr_en, i, (i == 255));
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (lvl_rd_en !== 1'b0 || clr_en !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL drain[%0d]: rd_en=%b clr=%b busy=%b required 0 0 1",
                         k, lvl_rd_en, clr_en, busy);
            end
            tick();
        end
        for (int i = 0; i < 256; i++) begin
            n_checks++;
            if (clr_en !== 1'b1 || clr_addr !== 8'(i) || histEQ_start_flag !== 1'b0 ||
                lvl_rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL clear[%0d]: clr=%b addr=%0d flag=%b required 1 %0d 0",
                         i, clr_en, clr_addr, histEQ_start_flag, i);
            end
            tick();
        end
        n_checks++;
        if (histEQ_start_flag !== 1'b1 || clr_en !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flag_set: flag=%b clr=%b busy=%b required 1 0 1",
                     histEQ_start_flag, clr_en, busy);
        end
    endtask

    task automatic test_drop();
        img_vsync = 1'b1; tick();
        img_href = 1'b1; repeat (5) tick();
        img_href = 1'b0; img_vsync = 1'b0; tick();
        n_checks++;
        if (frame_pix_cnt !== PW'(5) || histEQ_start_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_pre_cnt: pix=%0d flag=%b required 5 1", frame_pix_cnt,
                     histEQ_start_flag);
        end
        repeat (99) tick();
        img_vsync = 1'b1; tick();
        n_checks++;
        if (frame_drop !== 1'b1 || stat_en !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_pulse: drop=%b stat=%b required 1 0", frame_drop, stat_en);
        end
        img_href = 1'b1; tick();
        n_checks++;
        if (frame_drop !== 1'b0) begin
            n_fail++; $display("FAIL drop_width: drop=%b required 0", frame_drop);
        end
        repeat (8) tick();
        n_checks++;
        if (stat_en !== 1'b0) begin
            n_fail++; $display("FAIL drop_stat: stat_en=%b required 0", stat_en);
        end
        img_href = 1'b0; img_vsync = 1'b0;
        wait_clr_done("drop_seq");
        img_vsync = 1'b1; tick();
        n_checks++;
        if (stat_en !== 1'b1) begin
            n_fail++; $display("FAIL after_drop_stat: stat_en=%b required 1", stat_en);
        end
        img_href = 1'b1; repeat (7) tick();
        img_href = 1'b0; img_vsync = 1'b0; tick();
        n_checks++;
        if (frame_pix_cnt !== PW'(7)) begin
            n_fail++; $display("FAIL after_drop_cnt: pix=%0d required 7", frame_pix_cnt);
        end
        wait_clr_done("after_drop_seq");
    endtask

    task automatic test_enable_drop();
        img_vsync = 1'b1; tick();
        img_href = 1'b1; repeat (3) tick();
        enable = 1'b0; repeat (3) tick();
        img_href = 1'b0; img_vsync = 1'b0; tick();
        n_checks++;
        if (frame_pix_cnt !== PW'(6) || lvl_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL en_drop_cnt: pix=%0d rd_en=%b required 6 1", frame_pix_cnt, lvl_rd_en);
        end
        wait_clr_done("en_drop_seq");
        repeat (3) tick();
        n_checks++;
        if (busy !== 1'b0 || histEQ_start_flag !== 1'b0 || clr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL en_drop_idle: busy=%b flag=%b clr=%b required 0 0 0",
                     busy, histEQ_start_flag, clr_en);
        end
    endtask

    task automatic test_reset_mid_xfer();
        enable = 1'b1;
        wait_clr_done("reinit");
        img_vsync = 1'b1; tick();
        img_href = 1'b1; repeat (2) tick();
        img_href = 1'b0; img_vsync = 1'b0; tick();
        repeat (37) tick();
        n_checks++;
        if (lvl_rd_addr !== 8'd37 || lvl_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL xfer_addr37: addr=%0d rd_en=%b required 37 1", lvl_rd_addr, lvl_rd_en);
        end
        rst = 1'b1; tick();
        n_checks++;
        if ({stat_en, lvl_rd_en, lvl_rd_addr, lvl_rd_last, clr_en, clr_addr,
             histEQ_start_flag, busy, frame_drop, frame_pix_cnt} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: rd=%b ra=%0d bz=%b fl=%b pc=%0d required all 0",
                     lvl_rd_en, lvl_rd_addr, busy, histEQ_start_flag, frame_pix_cnt);
        end
        rst = 1'b0; tick();
        for (int i = 0; i < 256; i++) begin
            n_checks++;
            if (clr_en !== 1'b1 || clr_addr !== 8'(i) || stat_en !== 1'b0) begin
                n_fail++;
                $display("FAIL post_rst_clr[%0d]: clr=%b addr=%0d stat=%b required 1 %0d 0",
                         i, clr_en, clr_addr, stat_en, i);
            end
            tick();
        end
        n_checks++;
        if (clr_en !== 1'b0 || busy !== 1'b1 || histEQ_start_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL post_rst_wait: clr=%b busy=%b flag=%b required 0 1 0",
                     clr_en, busy, histEQ_start_flag);
        end
    endtask

    task automatic test_saturation();
        img_vsync = 1'b1; tick();
        img_href = 1'b1; repeat (1028) tick();
        img_href = 1'b0; img_vsync = 1'b0; tick();
        n_checks++;
        if (frame_pix_cnt !== PW'(1023)) begin
            n_fail++; $display("FAIL pix_saturate: pix=%0d required 1023", frame_pix_cnt);
        end
        wait_clr_done("sat_seq");
        n_checks++;
        if (histEQ_start_flag !== 1'b1) begin
            n_fail++; $display("FAIL sat_flag: flag=%b required 1", histEQ_start_flag);
        end
    endtask

    initial begin
        test_reset();
        test_init_clear();
        test_frame();
        test_drop();
        test_enable_drop();
        test_reset_mid_xfer();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
